// File: rtl/mem_loader_pkg.sv
// Shared constants and state encoding for the mem_loader byte-command front end.
// MEM_LOADER_CSUM_EN adds the checksum trailer state.
package mem_loader_pkg;

  localparam int ADDR_W = 12;
  localparam int BANK_HI = 11;
  localparam int BANK_LO = 10;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ = 8'h52;

  typedef enum logic [3:0] {
    S_IDLE,
    S_AHI,
    S_ALO,
    S_LEN,
    S_WDATA,
    S_RREQ,
    S_RWAIT,
    S_RSEND
`ifdef MEM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  function automatic logic takes_rx(state_t s);
    return s inside {S_IDLE, S_AHI, S_ALO, S_LEN, S_WDATA};
  endfunction

endpackage

// File: rtl/mem_loader_csum.sv
// Running 8-bit modulo-256 sum of command data bytes.
// Only instantiated when MEM_LOADER_CSUM_EN is defined.
module mem_loader_csum
  import mem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       acc,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (acc) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream command parser driving the banked memory port.
// Define MEM_LOADER_CSUM_EN to append a checksum byte to every command.
module mem_loader
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              err
);

`ifdef MEM_LOADER_CSUM_EN
  localparam state_t S_DONE = S_CSUM;
`else
  localparam state_t S_DONE = S_IDLE;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              is_rd;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        cnt;
  logic              rx_hs;
  logic              tx_hs;
  logic              last;
  logic              op_ok;

  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;
  assign last = (cnt == 8'd0);
  assign op_ok = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (rx_hs && op_ok) state_nxt = S_AHI;
      S_AHI:   if (rx_hs) state_nxt = S_ALO;
      S_ALO:   if (rx_hs) state_nxt = S_LEN;
      S_LEN:   if (rx_hs) state_nxt = is_rd ? S_RREQ : S_WDATA;
      S_WDATA: if (rx_hs && last) state_nxt = S_DONE;
      S_RREQ:  state_nxt = S_RWAIT;
      S_RWAIT: state_nxt = S_RSEND;
      S_RSEND: if (tx_hs) state_nxt = last ? S_DONE : S_RREQ;
`ifdef MEM_LOADER_CSUM_EN
      S_CSUM:  if (tx_hs) state_nxt = S_IDLE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MEM_LOADER_CSUM_EN
  logic [7:0] sum;

  mem_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_IDLE && rx_hs),
    .acc   ((state == S_WDATA && rx_hs) || state == S_RWAIT),
    .din   (state == S_RWAIT ? mem_rdata : rx_data),
    .sum   (sum)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      is_rd     <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
    end else begin
      rx_ready <= takes_rx(state_nxt);
      mem_we   <= 1'b0;
      mem_re   <= (state_nxt == S_RREQ);
      unique case (state)
        S_IDLE: if (rx_hs) begin
          is_rd <= (rx_data == OP_READ);
          if (!op_ok) err <= 1'b1;
        end
        S_AHI: if (rx_hs) begin
          // Upper nibble is flagged but masked; parsing continues.
          addr[ADDR_W-1:8] <= rx_data[3:0];
          if (rx_data[7:4] != 4'h0) err <= 1'b1;
        end
        S_ALO: if (rx_hs) addr[7:0] <= rx_data;
        S_LEN: if (rx_hs) begin
          cnt <= rx_data;
          if (is_rd) mem_addr <= addr;
        end
        S_WDATA: if (rx_hs) begin
          mem_we    <= 1'b1;
          mem_addr  <= addr;
          mem_wdata <= rx_data;
          addr      <= addr + ADDR_W'(1);
          cnt       <= cnt - 8'd1;
        end
        S_RWAIT: begin
          tx_data  <= mem_rdata;
          tx_valid <= 1'b1;
        end
        S_RSEND: if (tx_hs) begin
          tx_valid <= 1'b0;
          addr     <= addr + ADDR_W'(1);
          mem_addr <= addr + ADDR_W'(1);
          cnt      <= cnt - 8'd1;
        end
`ifdef MEM_LOADER_CSUM_EN
        S_CSUM: if (tx_hs) tx_valid <= 1'b0;
`endif
        default: ;
      endcase
`ifdef MEM_LOADER_CSUM_EN
      // The final write byte is not yet in the sum register.
      if (state_nxt == S_CSUM && state != S_CSUM) begin
        tx_valid <= 1'b1;
        tx_data  <= (state == S_WDATA) ? sum + rx_data : sum;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader with a behavioural 1-cycle-latency memory.
// Checksum expectations follow MEM_LOADER_CSUM_EN.
module tb_mem_loader;
  import mem_loader_pkg::*;

`ifdef MEM_LOADER_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  mem_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  logic [11:0] ra[$];
  int          rc[$];
  logic [7:0]  td[$];
  int          tc[$];
  int          both = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (mem_re) begin
      ra.push_back(mem_addr);
      rc.push_back(cyc);
    end
    if (mem_we && mem_re) both++;
    if (tx_valid && tx_ready) begin
      td.push_back(tx_data);
      tc.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_q();
    wa.delete(); wd.delete(); wc.delete();
    ra.delete(); rc.delete(); td.delete(); tc.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) check("rx_timeout", 32'(rx_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] f[]);
    foreach (f[i]) send(f[i]);
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((busy || mem_we) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_busy", 32'(busy), 32'd0);
  endtask

  logic [7:0] held;
  int         stable;
  int         t;

  initial begin
    #1;
    check("rst_flags", 32'({rx_ready, tx_valid, mem_we, mem_re, busy, err}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'({tx_data, mem_wdata}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rdy_pre", 32'(rx_ready), 32'd0);
    @(posedge clk); #1;
    check("rdy_post", 32'(rx_ready), 32'd1);

    // basic write
    clr_q();
    send_frame('{8'h57, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB});
    wait_done();
    check("w1_n", 32'(wa.size()), 32'd2);
    check("w1_a0", 32'({wa[0], wd[0]}), 32'h000AA);
    check("w1_a1", 32'({wa[1], wd[1]}), 32'h001BB);
    check("w1_gap", 32'(wc[1] - wc[0]), 32'd1);
    check("w1_tx_n", 32'(td.size()), 32'(CS));
`ifdef MEM_LOADER_CSUM_EN
    check("w1_sum", 32'(td[0]), 32'h65);
`endif

    // single read from bank 1
    send_frame('{8'h57, 8'h04, 8'h00, 8'h00, 8'hCC});
    wait_done();
    clr_q();
    send_frame('{8'h52, 8'h04, 8'h00, 8'h00});
    wait_done();
    check("r1_n", 32'(ra.size()), 32'd1);
    check("r1_addr", 32'(ra[0]), 32'h400);
    check("r1_tx", 32'(td[0]), 32'hCC);
    check("r1_lat", 32'(tc[0] - rc[0]), 32'd2);
    check("r1_nowe", 32'(wa.size()), 32'd0);
    check("r1_tx_n", 32'(td.size()), 32'(1 + CS));
`ifdef MEM_LOADER_CSUM_EN
    check("r1_sum", 32'(td[1]), 32'hCC);
`endif

    // wrap FFF -> 000
    clr_q();
    send_frame('{8'h57, 8'h0F, 8'hFF, 8'h01, 8'h11, 8'h22});
    wait_done();
    check("wr_a0", 32'({wa[0], wd[0]}), 32'hFFF11);
    check("wr_a1", 32'({wa[1], wd[1]}), 32'h00022);
    clr_q();
    send_frame('{8'h52, 8'h0F, 8'hFF, 8'h01});
    wait_done();
    check("rr_addr", 32'({ra[0], ra[1]}), 32'hFFF000);
    check("rr_tx", 32'({td[0], td[1]}), 32'h1122);

    // backpressure
    clr_q();
    tx_ready = 1'b0;
    send_frame('{8'h52, 8'h0F, 8'hFF, 8'h01});
    t = 0;
    while (!tx_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    held = tx_data;
    stable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (tx_valid && tx_data == held) stable++;
    end
    check("bp_hold", 32'(stable), 32'd5);
    check("bp_data", 32'(held), 32'h11);
    check("bp_re", 32'(ra.size()), 32'd1);
    tx_ready = 1'b1;
    wait_done();
    check("bp_re2", 32'(ra.size()), 32'd2);
    check("bp_tx", 32'({td[0], td[1]}), 32'h1122);
`ifdef MEM_LOADER_CSUM_EN
    check("bp_sum", 32'(td[2]), 32'h33);
`endif

    // bad opcode
    clr_q();
    check("err_pre", 32'(err), 32'd0);
    send_frame('{8'h33});
    @(posedge clk); #1;
    check("bad_err", 32'(err), 32'd1);
    check("bad_idle", 32'(busy), 32'd0);
    check("bad_nomem", 32'(wa.size() + ra.size()), 32'd0);
    send_frame('{8'h57, 8'h00, 8'h20, 8'h00, 8'h44});
    wait_done();
    check("bad_next", 32'({wa[0], wd[0]}), 32'h02044);

    // dirty addr_hi
    clr_q();
    send_frame('{8'h57, 8'hF1, 8'h23, 8'h00, 8'h5A});
    wait_done();
    check("ahi_w", 32'({wa[0], wd[0]}), 32'h1235A);
    check("ahi_err", 32'(err), 32'd1);

    // reset mid-write
    clr_q();
    send_frame('{8'h57, 8'h00, 8'h50, 8'h07, 8'h01, 8'h02, 8'h03});
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("mr_flags", 32'({rx_ready, tx_valid, mem_we, mem_re, busy, err}), 32'd0);
    check("mr_addr", 32'(mem_addr), 32'd0);
    check("mr_data", 32'({tx_data, mem_wdata}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mr_nw", 32'(wa.size()), 32'd3);
    check("mr_last", 32'({wa[2], wd[2]}), 32'h05203);
    send_frame('{8'h57, 8'h02, 8'h00, 8'h00, 8'h77});
    wait_done();
    check("mr_new", 32'({wa[3], wd[3]}), 32'h20077);

    check("no_we_re", 32'(both), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
